// File: rtl/dmem_pkg.sv
// Shared constants and FSM encoding for the data-memory arbiter.
package dmem_pkg;

  localparam int AW         = 32;
  localparam int DW         = 32;
  localparam int DMEM_DEPTH = 256;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin grant; last_grant advances whenever a grant is taken.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic en,
  output logic gnt
);

  logic last_grant;

  always_comb begin
    gnt = 1'b0;
    if (req0 && req1) gnt = ~last_grant;
    else if (req1)    gnt = 1'b1;
  end

  // Reset to 1 so port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst)     last_grant <= 1'b1;
    else if (en) last_grant <= gnt;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port DMEM arbiter/sequencer: grants one requester, strobes DMEM for one
// cycle, captures read data and returns a one-cycle ack (with err on bad address).
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | sampling req0/req1; grant and latch address/data on a request
// ST_ACCESS | one strobe cycle, DMEM acts on the mid-cycle negedge
// ST_RESP   | ack (and err if rejected) of the granted port for one cycle
module dmem_arbiter #(
  parameter int AW    = dmem_pkg::AW,
  parameter int DW    = dmem_pkg::DW,
  parameter int DEPTH = dmem_pkg::DMEM_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic          err0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic          err1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic [AW-1:0] DMEM_address,
  output logic [DW-1:0] DMEM_data_in,
  output logic          DMEM_mem_write,
  output logic          DMEM_mem_read,
  input  logic [DW-1:0] DMEM_data_out
);

  import dmem_pkg::*;

  state_t        state, state_nxt;
  logic          gnt, arb_en, sel_we, in_range, cur_port;
  logic [AW-1:0] sel_addr, depth_lim;
  logic [DW-1:0] sel_wdata;

  assign sel_we    = gnt ? we1    : we0;
  assign sel_addr  = gnt ? addr1  : addr0;
  assign sel_wdata = gnt ? wdata1 : wdata0;
  assign depth_lim = AW'(DEPTH);
  assign in_range  = sel_addr < depth_lim;
  assign arb_en    = (state == ST_IDLE) && (req0 || req1);

  rr_arb2 u_rr_arb2 (
    .clk  (clk),
    .rst  (rst),
    .req0 (req0),
    .req1 (req1),
    .en   (arb_en),
    .gnt  (gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (arb_en) state_nxt = in_range ? ST_ACCESS : ST_RESP;
      ST_ACCESS: state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered so strobes are glitch-free across the DMEM negedge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack0           <= 1'b0;
      ack1           <= 1'b0;
      err0           <= 1'b0;
      err1           <= 1'b0;
      busy           <= 1'b0;
      cur_port       <= 1'b0;
      rdata          <= '0;
      DMEM_address   <= '0;
      DMEM_data_in   <= '0;
      DMEM_mem_write <= 1'b0;
      DMEM_mem_read  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_en) begin
            cur_port       <= gnt;
            busy           <= 1'b1;
            DMEM_address   <= sel_addr;
            DMEM_data_in   <= sel_wdata;
            DMEM_mem_write <= in_range & sel_we;
            DMEM_mem_read  <= in_range & ~sel_we;
            // Rejected requests skip ACCESS, so the ack/err must be raised now.
            if (!in_range) begin
              ack0 <= ~gnt;
              ack1 <= gnt;
              err0 <= ~gnt;
              err1 <= gnt;
            end
          end
        end
        ST_ACCESS: begin
          DMEM_mem_write <= 1'b0;
          DMEM_mem_read  <= 1'b0;
          if (DMEM_mem_read) rdata <= DMEM_data_out;
          ack0 <= ~cur_port;
          ack1 <= cur_port;
        end
        ST_RESP: begin
          ack0 <= 1'b0;
          ack1 <= 1'b0;
          err0 <= 1'b0;
          err1 <= 1'b0;
          busy <= 1'b0;
        end
        default: begin
          busy           <= 1'b0;
          DMEM_mem_write <= 1'b0;
          DMEM_mem_read  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a negedge DMEM model and strobe monitor.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, ack0, err0;
  logic        req1, we1, ack1, err1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic [31:0] rdata;
  logic        busy;
  logic [31:0] DMEM_address, DMEM_data_in, DMEM_data_out;
  logic        DMEM_mem_write, DMEM_mem_read;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0, rd_cnt = 0, both_cnt = 0, outside_cnt = 0;
  logic [31:0] mem [256];

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .req0           (req0),
    .we0            (we0),
    .addr0          (addr0),
    .wdata0         (wdata0),
    .ack0           (ack0),
    .err0           (err0),
    .req1           (req1),
    .we1            (we1),
    .addr1          (addr1),
    .wdata1         (wdata1),
    .ack1           (ack1),
    .err1           (err1),
    .rdata          (rdata),
    .busy           (busy),
    .DMEM_address   (DMEM_address),
    .DMEM_data_in   (DMEM_data_in),
    .DMEM_mem_write (DMEM_mem_write),
    .DMEM_mem_read  (DMEM_mem_read),
    .DMEM_data_out  (DMEM_data_out)
  );

  // DMEM model acts on the negedge, like the real macro.
  always @(negedge clk) begin
    if (DMEM_mem_write) begin
      mem[DMEM_address[7:0]] <= DMEM_data_in;
      wr_cnt <= wr_cnt + 1;
    end
    if (DMEM_mem_read) begin
      DMEM_data_out <= mem[DMEM_address[7:0]];
      rd_cnt <= rd_cnt + 1;
    end
    if (DMEM_mem_write && DMEM_mem_read) both_cnt <= both_cnt + 1;
    if ((DMEM_mem_write || DMEM_mem_read) && !busy) outside_cnt <= outside_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input bit port, input bit we, input logic [31:0] addr,
                     input logic [31:0] wd, input int exp_lat, input bit exp_err,
                     input logic [31:0] exp_rd, input string tag);
    int lat, w0, r0;
    bit got;
    w0 = wr_cnt;
    r0 = rd_cnt;
    if (port) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd; end
    else      begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd; end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 8) begin
      tick();
      lat++;
      if (lat == 1 && !exp_err)
        chk({tag, "_strobe"}, 64'({DMEM_mem_write, DMEM_mem_read, DMEM_address}),
            64'({we, ~we, addr}));
      if (port ? ack1 : ack0) got = 1'b1;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_err"}, 64'(port ? err1 : err0), 64'(exp_err));
    chk({tag, "_other_ack"}, 64'(port ? ack0 : ack1), 64'd0);
    chk({tag, "_rdata"}, 64'(rdata), 64'(exp_rd));
    chk({tag, "_nwr"}, 64'(wr_cnt - w0), 64'((!exp_err && we) ? 1 : 0));
    chk({tag, "_nrd"}, 64'(rd_cnt - r0), 64'((!exp_err && !we) ? 1 : 0));
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
  endtask

  int ack_port [4];
  int ack_cyc  [4];
  int nacks, cyc, acks;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    DMEM_data_out = '0;
    rst = 1'b1;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    tick();
    tick();
    chk("rst_ack_err", 64'({ack0, ack1, err0, err1}), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_strobes", 64'({DMEM_mem_write, DMEM_mem_read}), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_addr_data", {DMEM_address, DMEM_data_in}, 64'd0);
    rst = 1'b0;
    tick();

    run(0, 1, 32'd5,   32'hDEADBEEF, 2, 0, 32'h0,        "wr5");
    run(0, 0, 32'd5,   32'h0,        2, 0, 32'hDEADBEEF, "rd5");
    run(1, 0, 32'd300, 32'h0,        1, 1, 32'hDEADBEEF, "oor300");
    run(0, 0, 32'd7,   32'h0,        2, 0, 32'h0,        "rd7");
    run(1, 1, 32'd255, 32'hA5A5A5A5, 2, 0, 32'h0,        "wr255");
    run(0, 1, 32'd256, 32'h11111111, 1, 1, 32'h0,        "oor256");
    run(1, 0, 32'h8000_0005, 32'h0,  1, 1, 32'h0,        "oor_hibit");
    run(1, 0, 32'd255, 32'h0,        2, 0, 32'hA5A5A5A5, "rd255");

    // Both ports holding requests after reset: strict alternation starting at 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0 = 1; we0 = 0; addr0 = 32'd5;
    req1 = 1; we1 = 0; addr1 = 32'd255;
    nacks = 0;
    cyc = 0;
    while (nacks < 4 && cyc < 20) begin
      tick();
      cyc++;
      if (ack0 || ack1) begin
        ack_port[nacks] = ack1 ? 1 : 0;
        ack_cyc[nacks]  = cyc;
        chk("tie_rdata", 64'(rdata), 64'(ack1 ? 32'hA5A5A5A5 : 32'hDEADBEEF));
        chk("tie_dual_ack", 64'(ack0 && ack1), 64'd0);
        nacks++;
      end
    end
    chk("tie_nacks", 64'(nacks), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("tie_order", 64'(ack_port[i]), 64'(i % 2));
      chk("tie_cycle", 64'(ack_cyc[i]), 64'(2 + 3 * i));
    end
    req0 = 0;
    req1 = 0;
    tick();

    // Port 1 requests while port 0 is in ACCESS.
    req0 = 1; we0 = 1; addr0 = 32'd10; wdata0 = 32'h0000_1234;
    tick();
    req1 = 1; we1 = 0; addr1 = 32'd10;
    tick();
    chk("late_ack0", 64'({ack0, ack1}), 64'b10);
    req0 = 0;
    cyc = 0;
    while (!ack1 && cyc < 10) begin
      tick();
      cyc++;
    end
    chk("late_gap", 64'(cyc), 64'd3);
    chk("late_rdata", 64'(rdata), 64'h0000_1234);
    req1 = 0;
    tick();

    // Reset during port 0 ACCESS; port 0 was the last grant beforehand.
    req0 = 1; we0 = 1; addr0 = 32'd20; wdata0 = 32'h55;
    tick();
    chk("rma_busy", 64'(busy), 64'd1);
    chk("rma_wr", 64'(DMEM_mem_write), 64'd1);
    rst = 1'b1;
    tick();
    chk("rma_strobes", 64'({DMEM_mem_write, DMEM_mem_read}), 64'd0);
    chk("rma_ack", 64'({ack0, ack1}), 64'd0);
    chk("rma_busy0", 64'(busy), 64'd0);
    req0 = 0;
    rst = 1'b0;
    acks = 0;
    repeat (3) begin
      tick();
      if (ack0 || ack1) acks++;
    end
    chk("rma_no_ack", 64'(acks), 64'd0);
    req0 = 1; we0 = 0; addr0 = 32'd5;
    req1 = 1; we1 = 0; addr1 = 32'd255;
    cyc = 0;
    while (!(ack0 || ack1) && cyc < 8) begin
      tick();
      cyc++;
    end
    chk("rma_tie_port", 64'({ack0, ack1}), 64'b10);
    chk("rma_tie_lat", 64'(cyc), 64'd2);
    req0 = 0;
    req1 = 0;
    tick();
    tick();

    chk("both_strobes", 64'(both_cnt), 64'd0);
    chk("strobe_idle", 64'(outside_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
